// File: rtl/fifo_fwft_pkt_reader_if.sv
// Handshake bundle between the FWFT FIFO read port, the packet reader and
// the downstream byte consumer. The reader uses the slave modport; the
// environment driving the FIFO and consuming bytes uses the master modport.
interface fifo_fwft_pkt_reader_if #(
    parameter int LenWidth = 8
);
    logic                enable;
    logic [8:0]          fifo_dout;
    logic                fifo_empty;
    logic                fifo_read;
    logic [7:0]          out_data;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;
    logic                pkt_done;
    logic [LenWidth-1:0] pkt_len;
    logic                pkt_err;
    logic [7:0]          pkt_csum;

    modport slave (
        input  enable, fifo_dout, fifo_empty, out_ready,
        output fifo_read, out_data, out_last, out_valid,
               pkt_done, pkt_len, pkt_err, pkt_csum
    );

    modport master (
        output enable, fifo_dout, fifo_empty, out_ready,
        input  fifo_read, out_data, out_last, out_valid,
               pkt_done, pkt_len, pkt_err, pkt_csum
    );
endinterface

// File: rtl/fifo_fwft_pkt_reader.sv
// Read-side packet engine for 9-bit FWFT FIFOs (bit 8 = end of packet).
// Pops words, presents a registered byte stream, truncates packets that
// reach MaxLen bytes without EOP and drops their remainder, and reports
// per-packet length / truncation status on completion.
// Optional XOR checksum of emitted bytes: define FIFO_PKT_RD_CSUM_EN.
//
// state   | meaning
// IDLE    | between packets; a pop here needs enable
// STREAM  | inside a packet; runs to EOP regardless of enable
// DISCARD | packet was truncated; drop words up to and including EOP
module fifo_fwft_pkt_reader #(
    parameter int MaxLen   = 64,
    parameter int LenWidth = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    fifo_fwft_pkt_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [LenWidth-1:0] MaxLenC = LenWidth'(MaxLen);

    state_t              state_q, state_d;
    logic [LenWidth-1:0] len_q, len_d, len_inc;
    logic                run_q;
    logic                fifo_read, pop_out, eop, trunc, out_free, handshake;

    logic [7:0]          out_data_q;
    logic                out_last_q, out_valid_q, out_err_q;
    logic [LenWidth-1:0] out_len_q, pkt_len_q;
    logic                pkt_done_q, pkt_err_q;

    // run_q is cleared asynchronously, so no pop can be requested while
    // reset is held even though the request path is combinational.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) run_q <= 1'b0;
        else       run_q <= 1'b1;
    end

    // Pop decision, truncation detect and next state / length.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        fifo_read = 1'b0;
        out_free  = !out_valid_q || bus.out_ready;
        len_inc   = len_q + LenWidth'(1);
        case (state_q)
            IDLE:    fifo_read = run_q && bus.enable && !bus.fifo_empty && out_free;
            STREAM:  fifo_read = run_q && !bus.fifo_empty && out_free;
            DISCARD: fifo_read = run_q && !bus.fifo_empty;
            default: fifo_read = 1'b0;
        endcase
        pop_out   = fifo_read && (state_q != DISCARD);
        eop       = pop_out && bus.fifo_dout[8];
        trunc     = pop_out && !bus.fifo_dout[8] && (len_inc == MaxLenC);
        handshake = out_valid_q && bus.out_ready && out_last_q;
        if (pop_out) begin
            len_d   = (eop || trunc) ? '0 : len_inc;
            state_d = eop ? IDLE : (trunc ? DISCARD : STREAM);
        end else if (state_q == DISCARD && fifo_read && bus.fifo_dout[8]) begin
            state_d = IDLE;
        end
    end

    // State and running length registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Output register; byte count and truncation flag ride along with the
    // byte so back-to-back packets report their own status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (pop_out) begin
            out_data_q  <= bus.fifo_dout[7:0];
            out_last_q  <= bus.fifo_dout[8] || trunc;
            out_valid_q <= 1'b1;
            out_len_q   <= len_inc;
            out_err_q   <= trunc;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completion reporting on acceptance of the last byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            pkt_len_q  <= '0;
        end else begin
            pkt_done_q <= handshake;
            pkt_err_q  <= handshake && out_err_q;
            if (handshake) pkt_len_q <= out_len_q;
        end
    end

`ifdef FIFO_PKT_RD_CSUM_EN
    logic [7:0] csum_q, out_csum_q, pkt_csum_q;

    // Running XOR of emitted bytes; restarts after EOP or truncation so
    // discarded words never contribute.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q     <= '0;
            out_csum_q <= '0;
            pkt_csum_q <= '0;
        end else begin
            if (pop_out) begin
                csum_q     <= (eop || trunc) ? 8'h00 : (csum_q ^ bus.fifo_dout[7:0]);
                out_csum_q <= csum_q ^ bus.fifo_dout[7:0];
            end
            if (handshake) pkt_csum_q <= out_csum_q;
        end
    end

    assign bus.pkt_csum = pkt_csum_q;
`else
    assign bus.pkt_csum = 8'h00;
`endif

    assign bus.fifo_read = fifo_read;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.pkt_err   = pkt_err_q;
endmodule

// File: tb/tb_fifo_fwft_pkt_reader.sv
// Directed bench for fifo_fwft_pkt_reader with MaxLen=5: a FWFT FIFO model
// feeds the reader, a negedge monitor records accepted bytes and completion
// reports, and each test task compares them against hand-computed values.
module tb_fifo_fwft_pkt_reader;
    localparam int LW = 8;
    localparam int ML = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_fwft_pkt_reader_if #(.LenWidth(LW)) bus ();

    fifo_fwft_pkt_reader #(.MaxLen(ML), .LenWidth(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // FIFO model
    logic [8:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic       hold_empty = 1'b0;
    logic       flush = 1'b0;
    logic       enable = 1'b0;
    logic       out_ready = 1'b1;

    assign bus.fifo_dout  = mem[rd_ptr];
    assign bus.fifo_empty = (rd_ptr == wr_ptr) || hold_empty;
    assign bus.enable     = enable;
    assign bus.out_ready  = out_ready;

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (bus.fifo_read && !bus.fifo_empty) rd_ptr <= rd_ptr + 8'd1;
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    logic [8:0]  byte_q [$];
    int          bcyc_q [$];
    logic [16:0] done_q [$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                byte_q.push_back({bus.out_last, bus.out_data});
                bcyc_q.push_back(cyc);
            end
            if (bus.pkt_done) done_q.push_back({bus.pkt_len, bus.pkt_err, bus.pkt_csum});
        end
        if (bus.fifo_read) begin
            vectors++;
            if (bus.fifo_empty) begin
                errors++;
                $display("FAIL read_while_empty cyc=%0d fifo_read=1 required 0", cyc);
            end
        end
    end

    function automatic logic [7:0] ecs(input logic [7:0] x);
`ifdef FIFO_PKT_RD_CSUM_EN
        return x;
`else
        return 8'h00;
`endif
    endfunction

    task automatic push(input logic [8:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_until(input int nd, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (done_q.size() >= nd) break;
            tick(1);
        end
        ok = (done_q.size() >= nd);
    endtask

    task automatic clear_mon();
        byte_q.delete();
        bcyc_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        #2;
        push(9'h1FF);
        enable = 1'b1;
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== 10'h0) begin
            errors++; $display("FAIL reset_out got=%h required 000", {bus.out_valid, bus.out_last, bus.out_data});
        end
        vectors++;
        if ({bus.pkt_done, bus.pkt_err, bus.pkt_len, bus.pkt_csum} !== 18'h0) begin
            errors++; $display("FAIL reset_pkt got=%h required 0", {bus.pkt_done, bus.pkt_err, bus.pkt_len, bus.pkt_csum});
        end
        vectors++;
        if (bus.fifo_read !== 1'b0) begin
            errors++; $display("FAIL reset_fifo_read got=%b required 0", bus.fifo_read);
        end
        flush = 1'b1;
        tick(2);
        vectors++;
        if (bus.fifo_read !== 1'b0) begin
            errors++; $display("FAIL reset_fifo_read_held got=%b required 0", bus.fifo_read);
        end
        flush = 1'b0;
        enable = 1'b0;
        rst = 1'b0;
        tick(2);
        clear_mon();
    endtask

    task automatic test_basic();
        logic [8:0] eb [3] = '{9'h0A1, 9'h0B2, 9'h1C3};
        bit ok;
        enable = 1'b1; out_ready = 1'b1;
        push(9'h0A1); push(9'h0B2); push(9'h1C3);
        run_until(1, 30, ok);
        tick(3);
        vectors++;
        if (!ok || byte_q.size() != 3) begin
            errors++; $display("FAIL basic_count bytes=%0d required 3 done=%0d", byte_q.size(), done_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= byte_q.size() || byte_q[i] !== eb[i]) begin
                errors++; $display("FAIL basic_byte%0d got=%h required %h", i, (i < byte_q.size()) ? byte_q[i] : 9'hx, eb[i]);
            end
        end
        vectors++;
        if (bcyc_q.size() != 3 || bcyc_q[2] - bcyc_q[0] != 2) begin
            errors++; $display("FAIL basic_consecutive got span=%0d required 2", (bcyc_q.size() == 3) ? bcyc_q[2] - bcyc_q[0] : -1);
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] !== {8'd3, 1'b0, ecs(8'hD0)}) begin
            errors++; $display("FAIL basic_done n=%0d got=%h required %h", done_q.size(), (done_q.size() > 0) ? done_q[0] : 17'hx, {8'd3, 1'b0, ecs(8'hD0)});
        end
        vectors++;
        if (bus.pkt_len !== 8'd3 || bus.pkt_done !== 1'b0) begin
            errors++; $display("FAIL basic_len_held got len=%0d done=%b required 3 0", bus.pkt_len, bus.pkt_done);
        end
        clear_mon();
    endtask

    task automatic test_stall();
        logic [8:0] eb [3] = '{9'h0A1, 9'h0B2, 9'h1C3};
        bit prev_stall = 0;
        logic [8:0] held = '0;
        enable = 1'b1; out_ready = 1'b0;
        push(9'h0A1); push(9'h0B2); push(9'h1C3);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                vectors++;
                if (!bus.out_valid || {bus.out_last, bus.out_data} !== held) begin
                    errors++; $display("FAIL stall_hold got=%b/%h required 1/%h", bus.out_valid, {bus.out_last, bus.out_data}, held);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                vectors++;
                if (bus.fifo_read !== 1'b0) begin
                    errors++; $display("FAIL stall_pop got fifo_read=%b required 0", bus.fifo_read);
                end
                prev_stall = 1;
                held = {bus.out_last, bus.out_data};
            end else begin
                prev_stall = 0;
            end
            if (done_q.size() >= 1) break;
            @(posedge clk); #1;
            out_ready = !out_ready;
        end
        out_ready = 1'b1;
        tick(3);
        vectors++;
        if (byte_q.size() != 3) begin
            errors++; $display("FAIL stall_count got=%0d required 3", byte_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= byte_q.size() || byte_q[i] !== eb[i]) begin
                errors++; $display("FAIL stall_byte%0d got=%h required %h", i, (i < byte_q.size()) ? byte_q[i] : 9'hx, eb[i]);
            end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] !== {8'd3, 1'b0, ecs(8'hD0)}) begin
            errors++; $display("FAIL stall_done n=%0d required 1 len3", done_q.size());
        end
        clear_mon();
    endtask

    task automatic test_truncate();
        logic [8:0]  eb [6] = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h105, 9'h155};
        logic [16:0] ed [2];
        bit ok;
        ed[0] = {8'd5, 1'b1, ecs(8'h01)};
        ed[1] = {8'd1, 1'b0, ecs(8'h55)};
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) push(9'(i));
        push(9'h107);
        push(9'h155);
        run_until(2, 40, ok);
        tick(3);
        vectors++;
        if (!ok || byte_q.size() != 6) begin
            errors++; $display("FAIL trunc_count bytes=%0d required 6", byte_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= byte_q.size() || byte_q[i] !== eb[i]) begin
                errors++; $display("FAIL trunc_byte%0d got=%h required %h", i, (i < byte_q.size()) ? byte_q[i] : 9'hx, eb[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= done_q.size() || done_q[i] !== ed[i]) begin
                errors++; $display("FAIL trunc_done%0d got=%h required %h", i, (i < done_q.size()) ? done_q[i] : 17'hx, ed[i]);
            end
        end
        vectors++;
        if (rd_ptr !== wr_ptr) begin
            errors++; $display("FAIL trunc_drained rd=%0d required %0d", rd_ptr, wr_ptr);
        end
        clear_mon();
    endtask

    task automatic test_enable();
        bit ok;
        enable = 1'b0; out_ready = 1'b1;
        push(9'h011); push(9'h012); push(9'h013); push(9'h014); push(9'h115);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.fifo_read !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL enable_off got rd=%b valid=%b required 0 0", bus.fifo_read, bus.out_valid);
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        run_until(1, 30, ok);
        tick(2);
        vectors++;
        if (!ok || byte_q.size() != 5 || byte_q[4] !== 9'h115) begin
            errors++; $display("FAIL enable_mid bytes=%0d required 5", byte_q.size());
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] !== {8'd5, 1'b0, ecs(8'h11)}) begin
            errors++; $display("FAIL enable_done got=%h required %h", (done_q.size() > 0) ? done_q[0] : 17'hx, {8'd5, 1'b0, ecs(8'h11)});
        end
        push(9'h1AA);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.fifo_read !== 1'b0) begin
                errors++; $display("FAIL enable_idle_pop got=%b required 0", bus.fifo_read);
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        run_until(2, 20, ok);
        tick(2);
        vectors++;
        if (!ok || done_q[1] !== {8'd1, 1'b0, ecs(8'hAA)}) begin
            errors++; $display("FAIL enable_resume n=%0d required 2", done_q.size());
        end
        clear_mon();
    endtask

    task automatic test_reset_mid();
        bit ok;
        enable = 1'b1; out_ready = 1'b0;
        push(9'h021); push(9'h022); push(9'h123);
        tick(3);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h21) begin
            errors++; $display("FAIL rmid_pre got=%b/%h required 1/21", bus.out_valid, bus.out_data);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_last, bus.out_data, bus.fifo_read, bus.pkt_done} !== 12'h0) begin
            errors++; $display("FAIL rmid_async got=%h required 000", {bus.out_valid, bus.out_last, bus.out_data, bus.fifo_read, bus.pkt_done});
        end
        flush = 1'b1;
        tick(2);
        flush = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        tick(1);
        vectors++;
        if (done_q.size() != 0) begin
            errors++; $display("FAIL rmid_nodone got=%0d required 0", done_q.size());
        end
        clear_mon();
        push(9'h011); push(9'h122);
        run_until(1, 20, ok);
        tick(2);
        vectors++;
        if (!ok || byte_q.size() != 2 || byte_q[0] !== 9'h011 || byte_q[1] !== 9'h122) begin
            errors++; $display("FAIL rmid_bytes n=%0d required 2", byte_q.size());
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] !== {8'd2, 1'b0, ecs(8'h33)}) begin
            errors++; $display("FAIL rmid_done got=%h required %h", (done_q.size() > 0) ? done_q[0] : 17'hx, {8'd2, 1'b0, ecs(8'h33)});
        end
        clear_mon();
    endtask

    task automatic test_gappy();
        bit ok = 0;
        enable = 1'b1; out_ready = 1'b1;
        hold_empty = 1'b1;
        push(9'h031); push(9'h032); push(9'h133);
        for (int c = 0; c < 30; c++) begin
            if (done_q.size() >= 1) begin ok = 1; break; end
            tick(1);
            hold_empty = !hold_empty;
        end
        hold_empty = 1'b0;
        tick(2);
        vectors++;
        if (!ok || byte_q.size() != 3 || byte_q[2] !== 9'h133) begin
            errors++; $display("FAIL gappy_bytes n=%0d required 3", byte_q.size());
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] !== {8'd3, 1'b0, ecs(8'h30)}) begin
            errors++; $display("FAIL gappy_done got=%h required %h", (done_q.size() > 0) ? done_q[0] : 17'hx, {8'd3, 1'b0, ecs(8'h30)});
        end
        clear_mon();
    endtask

    task automatic test_back_to_back();
        logic [16:0] ed [3];
        bit ok;
        ed[0] = {8'd1, 1'b0, ecs(8'h41)};
        ed[1] = {8'd2, 1'b0, ecs(8'h01)};
        ed[2] = {8'd1, 1'b0, ecs(8'h44)};
        enable = 1'b1; out_ready = 1'b1;
        push(9'h141); push(9'h042); push(9'h143); push(9'h144);
        run_until(3, 30, ok);
        tick(3);
        vectors++;
        if (!ok || bcyc_q.size() != 4 || bcyc_q[3] - bcyc_q[0] != 3) begin
            errors++; $display("FAIL b2b_rate n=%0d required 4 consecutive", bcyc_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= done_q.size() || done_q[i] !== ed[i]) begin
                errors++; $display("FAIL b2b_done%0d got=%h required %h", i, (i < done_q.size()) ? done_q[i] : 17'hx, ed[i]);
            end
        end
        vectors++;
        if (done_q.size() != 3) begin
            errors++; $display("FAIL b2b_done_count got=%0d required 3", done_q.size());
        end
        clear_mon();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_truncate();
        test_enable();
        test_reset_mid();
        test_gappy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
